// File: rtl/sym9_gen_pkg.sv
// Shared types and combination helpers for the 9-input symmetric-function
// vector generator.
package sym9_gen_pkg;

    localparam int N = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Smallest N-bit value of weight k: the k low bits set.
    function automatic logic [N-1:0] base_comb(input logic [3:0] k);
        logic [N:0] one_hot;
        one_hot = (N+1)'(1) << k;
        return N'(one_hot - (N+1)'(1));
    endfunction

    // Largest N-bit value of weight k: the k high bits set (0 for k=0).
    function automatic logic [N-1:0] top_comb(input logic [3:0] k);
        if (k == 4'd0) begin
            return '0;
        end
        return base_comb(k) << (4'(N) - k);
    endfunction

    function automatic logic [3:0] popcnt9(input logic [N-1:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sym9_gosper_next.sv
// Gosper successor: next larger 9-bit value with the same popcount.
// Only meaningful for inputs that are not the top combination of their weight.
module sym9_gosper_next
    import sym9_gen_pkg::*;
(
    input  logic [N-1:0] vec,
    output logic [N-1:0] next_vec
);

    logic [N-1:0] lsb;
    logic [N-1:0] ripple;
    logic [N-1:0] spread;
    logic [3:0]   tz;

    // A non-top input always has a larger same-weight successor, so the
    // ripple add cannot carry out of 9 bits and the 9-bit path is exact.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, otherwise a latch is inferred.
        tz = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                tz = 4'(i);
            end
        end
        lsb      = vec & (~vec + N'(1));
        ripple   = vec + lsb;
        spread   = ((vec ^ ripple) >> 2) >> tz;
        next_vec = ripple | spread;
    end

endmodule

// File: rtl/sym9_vector_gen.sv
// Streams every 9-bit vector whose popcount lies in [weight_lo, weight_hi],
// with its golden symmetric output. Optional running sum: SYM9_GEN_SIGNATURE_EN.
module sym9_vector_gen #(
    parameter int PASS_LO = 3,
    parameter int PASS_HI = 6,
    parameter int N       = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  weight_lo,
    input  logic [3:0]  weight_hi,
    input  logic        abort,
    output logic [8:0]  vec,
    output logic        vec_exp,
    output logic        vec_valid,
    input  logic        vec_ready,
    output logic        vec_last,
    output logic [9:0]  beat_cnt,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] sig
);

    import sym9_gen_pkg::*;

    if (N != 9) begin : g_bad_width
        $error("sym9_vector_gen: N must be 9");
    end

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_EMIT = EMIT;
    localparam logic [1:0] ST_DONE = DONE;

    function automatic logic in_window(input logic [3:0] w);
        return (int'(w) >= PASS_LO) && (int'(w) <= PASS_HI);
    endfunction

    logic [1:0] state;
    logic [3:0] k;
    logic [3:0] hi_q;
    logic [8:0] succ;
    logic       at_top;
    logic       hs;
    logic       range_ok;
    logic       start_ok;

    sym9_gosper_next u_next (
        .vec      (vec),
        .next_vec (succ)
    );

    assign range_ok = (weight_lo <= weight_hi) && (weight_hi <= 4'd9);
    assign start_ok = (state == ST_IDLE) && start && range_ok;
    assign hs       = vec_valid && vec_ready;
    assign at_top   = (vec == top_comb(k));
    assign vec_last = vec_valid && at_top && (k == hi_q);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= ST_IDLE;
            k         <= 4'd0;
            hi_q      <= 4'd0;
            vec       <= '0;
            vec_exp   <= 1'b0;
            vec_valid <= 1'b0;
            beat_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state     <= ST_EMIT;
                        k         <= weight_lo;
                        hi_q      <= weight_hi;
                        vec       <= base_comb(weight_lo);
                        vec_exp   <= in_window(weight_lo);
                        vec_valid <= 1'b1;
                        beat_cnt  <= '0;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (hs) begin
                        beat_cnt <= beat_cnt + 10'd1;
                    end
                    // Abort wins over advancing; a beat taken on the same edge still counts.
                    if (abort) begin
                        state     <= ST_IDLE;
                        vec_valid <= 1'b0;
                    end else if (hs) begin
                        if (at_top && (k == hi_q)) begin
                            state     <= ST_DONE;
                            vec_valid <= 1'b0;
                        end else if (at_top) begin
                            k       <= k + 4'd1;
                            vec     <= base_comb(k + 4'd1);
                            vec_exp <= in_window(k + 4'd1);
                        end else begin
                            vec     <= succ;
                            vec_exp <= in_window(popcnt9(succ));
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SYM9_GEN_SIGNATURE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (start_ok) begin
            sig <= '0;
        end else if (hs) begin
            sig <= sig + {7'd0, vec};
        end
    end
`else
    assign sig = '0;
`endif

endmodule
